// File: rtl/spdif_frame_scheduler.sv
// Pair FIFO and frame sequencer feeding an S/PDIF transmitter: priming, underrun
// concealment, 192-frame block position and channel-status bit generation.
module spdif_frame_scheduler #(
  parameter int DATA_W           = 24,
  parameter int FIFO_DEPTH       = 4,
  parameter int PRIME_LEVEL      = 2,
  parameter bit MUTE_ON_UNDERRUN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        sample_rate_code,
  input  logic              tx_req,
  output logic [31:0]       data_left,
  output logic [31:0]       data_right,
  output logic              validity,
  output logic              cs_bit,
  output logic              block_start,
  output logic [7:0]        frame_index,
  output logic [15:0]       underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST_FRAME = 8'd191;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_right [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, level;
  logic              full, empty, flush, frame, push, pop, underrun;
  logic              first;
  logic [3:0]        cs_code, cs_code_next;
  logic [7:0]        index_next;

  // Channel-status block: consumer, copy permitted, sample rate in bits 24..27.
  function automatic logic cs_lookup(input logic [7:0] idx, input logic [3:0] code);
    if (idx == 8'd2)                      return 1'b1;
    else if (idx >= 8'd24 && idx <= 8'd27) return code[idx[1:0]];
    else                                   return 1'b0;
  endfunction

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full;

  assign flush = !enable || (state == IDLE);
  assign frame = tx_req && !flush;
  assign push  = in_valid && in_ready && !flush;

  assign index_next   = first ? 8'd0
                      : (frame_index == LAST_FRAME) ? 8'd0 : 8'(frame_index + 8'd1);
  assign cs_code_next = (index_next == 8'd0) ? sample_rate_code : cs_code;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next = state;
    pop        = 1'b0;
    underrun   = 1'b0;
    case (state)
      IDLE:  if (enable) state_next = PRIME;
      PRIME: if (frame && level >= (AW+1)'(PRIME_LEVEL)) begin
               pop        = 1'b1;
               state_next = RUN;
             end
      RUN:   if (frame) begin
               if (!empty) pop = 1'b1;
               else begin
                 underrun   = 1'b1;
                 state_next = PRIME;
               end
             end
      default: state_next = IDLE;
    endcase
    if (!enable) begin
      state_next = IDLE;
      pop        = 1'b0;
      underrun   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: storage array is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_left[wr_ptr[AW-1:0]]  <= in_left;
      mem_right[wr_ptr[AW-1:0]] <= in_right;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_left   <= '0;
      data_right  <= '0;
      validity    <= 1'b1;
      cs_bit      <= 1'b0;
      block_start <= 1'b1;
      frame_index <= '0;
      first       <= 1'b1;
      cs_code     <= '0;
    end else if (flush) begin
      data_left   <= '0;
      data_right  <= '0;
      validity    <= 1'b1;
      cs_bit      <= 1'b0;
      block_start <= 1'b1;
      frame_index <= '0;
      first       <= 1'b1;
    end else if (frame) begin
      first       <= 1'b0;
      frame_index <= index_next;
      block_start <= (index_next == 8'd0);
      cs_code     <= cs_code_next;
      cs_bit      <= cs_lookup(index_next, cs_code_next);
      validity    <= !pop;
      if (pop) begin
        data_left  <= 32'(mem_left[rd_ptr[AW-1:0]]);
        data_right <= 32'(mem_right[rd_ptr[AW-1:0]]);
      end else if (!underrun || MUTE_ON_UNDERRUN) begin
        // Priming frames are always silent; an underrun frame repeats the last pair only when not muting.
        data_left  <= '0;
        data_right <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) underrun_count <= '0;
    else if (underrun && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
  end

endmodule

// File: tb/tb_spdif_frame_scheduler.sv
// Randomized scoreboard bench for spdif_frame_scheduler: a muting and a holding
// instance share stimulus and are checked against a queue-based frame model.
module tb_spdif_frame_scheduler;
  localparam int DEPTH = 4;
  localparam int PL    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, in_valid, tx_req;
  logic [23:0] in_left, in_right;
  logic [3:0]  code;

  logic        m_ready, m_valid, m_cs, m_bs;
  logic [31:0] m_l, m_r;
  logic [7:0]  m_idx;
  logic [15:0] m_uc;
  logic        h_ready, h_valid, h_cs, h_bs;
  logic [31:0] h_l, h_r;
  logic [7:0]  h_idx;
  logic [15:0] h_uc;

  spdif_frame_scheduler #(.DATA_W(24), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .MUTE_ON_UNDERRUN(1'b1)) dut_mute (
    .clk(clk), .rst(rst), .enable(enable), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(m_ready), .sample_rate_code(code), .tx_req(tx_req),
    .data_left(m_l), .data_right(m_r), .validity(m_valid), .cs_bit(m_cs),
    .block_start(m_bs), .frame_index(m_idx), .underrun_count(m_uc));

  spdif_frame_scheduler #(.DATA_W(24), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PL), .MUTE_ON_UNDERRUN(1'b0)) dut_hold (
    .clk(clk), .rst(rst), .enable(enable), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(h_ready), .sample_rate_code(code), .tx_req(tx_req),
    .data_left(h_l), .data_right(h_r), .validity(h_valid), .cs_bit(h_cs),
    .block_start(h_bs), .frame_index(h_idx), .underrun_count(h_uc));

  typedef struct {
    logic [31:0] l, r, hl, hr;
    logic        v, cs, bs;
    logic [7:0]  idx;
    logic [15:0] uc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: what the stream should look like, not how the RTL builds it.
  bit          md_active, md_running, md_first;
  int          md_fnum, md_uc;
  logic [3:0]  md_code;
  logic [23:0] q_l[$], q_r[$];
  logic [31:0] hold_l, hold_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit cs_of(input int n, input logic [3:0] c);
    if (n == 2) return 1'b1;
    if (n >= 24 && n <= 27) return c[n-24];
    return 1'b0;
  endfunction

  task automatic model_reset();
    md_active = 0; md_running = 0; md_first = 1; md_fnum = 0; md_uc = 0;
    md_code = 4'd0; hold_l = 0; hold_r = 0;
    q_l.delete(); q_r.delete();
  endtask

  // Monitor: a frame request sampled at a rising edge is compared on the following falling edge.
  logic chk_req = 1'b0;
  logic due     = 1'b0;
  always @(posedge clk) due <= chk_req;

  always @(negedge clk) begin
    if (due && rst) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard: frame output with no expectation at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mute.data_left",  m_l, e.l);
        check("mute.data_right", m_r, e.r);
        check("hold.data_left",  h_l, e.hl);
        check("hold.data_right", h_r, e.hr);
        check("mute.validity",   m_valid, e.v);
        check("hold.validity",   h_valid, e.v);
        check("cs_bit",          m_cs, e.cs);
        check("block_start",     m_bs, e.bs);
        check("frame_index",     m_idx, e.idx);
        check("underrun_count",  m_uc, e.uc);
      end
    end
  end

  // One clock of stimulus, called just after a rising edge; the model advances alongside.
  task automatic step(input bit en, input bit vld, input logic [23:0] l, input logic [23:0] r, input bit tx);
    exp_t e;
    bit   pushed;
    int   lvl;
    pushed = 0;
    enable = en; in_valid = vld; in_left = l; in_right = r; tx_req = tx;
    if (vld) check("in_ready", m_ready, q_l.size() < DEPTH);
    if (!en) begin
      if (md_active) begin
        e = '{l: 0, r: 0, hl: 0, hr: 0, v: 1, cs: 0, bs: 1, idx: 0, uc: md_uc[15:0]};
        exp_q.push_back(e);
        pushed = 1;
      end
      md_active = 0; md_running = 0;
      q_l.delete(); q_r.delete();
    end else if (!md_active) begin
      md_active = 1; md_first = 1;
    end else begin
      lvl = q_l.size();
      if (tx) begin
        md_fnum  = md_first ? 0 : (md_fnum + 1) % 192;
        md_first = 0;
        if (md_fnum == 0) md_code = code;
        e.idx = md_fnum[7:0];
        e.bs  = (md_fnum == 0);
        e.cs  = cs_of(md_fnum, md_code);
        if (md_running ? (lvl > 0) : (lvl >= PL)) begin
          e.l  = 32'(q_l.pop_front());
          e.r  = 32'(q_r.pop_front());
          e.hl = e.l; e.hr = e.r; e.v = 0;
          md_running = 1;
        end else if (md_running) begin
          e.l = 0; e.r = 0; e.hl = hold_l; e.hr = hold_r; e.v = 1;
          if (md_uc < 16'hFFFF) md_uc++;
          md_running = 0;
        end else begin
          e.l = 0; e.r = 0; e.hl = 0; e.hr = 0; e.v = 1;
        end
        hold_l = e.hl; hold_r = e.hr;
        e.uc = md_uc[15:0];
        exp_q.push_back(e);
        pushed = 1;
      end
      if (vld && lvl < DEPTH) begin
        q_l.push_back(l);
        q_r.push_back(r);
      end
    end
    chk_req = pushed;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic stream(input int frames, input int push_pct);
    int gap;
    for (int f = 0; f < frames; f++) begin
      gap = $urandom_range(2, 5);
      step(1, $urandom_range(0, 99) < push_pct, 24'($urandom), 24'($urandom), 1);
      for (int g = 1; g < gap; g++)
        step(1, $urandom_range(0, 99) < push_pct, 24'($urandom), 24'($urandom), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag, input logic [15:0] uc);
    check({tag, ".in_ready"},    m_ready, 1);
    check({tag, ".data_left"},   m_l, 0);
    check({tag, ".data_right"},  m_r, 0);
    check({tag, ".hold_left"},   h_l, 0);
    check({tag, ".validity"},    m_valid, 1);
    check({tag, ".cs_bit"},      m_cs, 0);
    check({tag, ".block_start"}, m_bs, 1);
    check({tag, ".frame_index"}, m_idx, 0);
    check({tag, ".underrun"},    m_uc, uc);
  endtask

  initial begin
    bit code_changed;
    rst = 1'b0; enable = 0; in_valid = 0; tx_req = 0; in_left = 0; in_right = 0;
    code = 4'b1100;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset", 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Start-up: two known pairs, then slow frame requests through an underrun.
    step(1, 0, 0, 0, 0);
    step(1, 1, 24'h000001, 24'h000002, 0);
    step(1, 1, 24'h000003, 24'h000004, 0);
    repeat (5) begin
      step(1, 0, 0, 0, 1);
      repeat (127) step(1, 0, 0, 0, 0);
    end

    // Dense stream across block boundaries with a mid-block rate-code change.
    code_changed = 0;
    for (int f = 0; f < 440; f++) begin
      if (!code_changed && f >= 200 && md_fnum == 10) begin
        code = 4'b0000;
        code_changed = 1;
      end
      stream(1, 75);
    end

    // Starved input: repeated underruns and re-priming.
    stream(80, 22);
    stream(20, 75);

    // Disable mid-stream: FIFO flushed, index restarts, underrun count kept.
    step(0, 1, 24'($urandom), 24'($urandom), 0);
    step(0, 0, 0, 0, 0);
    check_reset_outputs("disable", 16'(md_uc));
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    stream(30, 75);

    // Asynchronous reset between clock edges.
    repeat (3) step(1, 0, 0, 0, 0);
    #3 rst = 1'b0;
    #1 check_reset_outputs("async_reset", 16'd0);
    model_reset();
    check("scoreboard_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0);
    stream(20, 75);

    repeat (4) step(1, 0, 0, 0, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spdif_frame_scheduler.md
# spdif_frame_scheduler

Sequences audio sample pairs into the S/PDIF transmitter. It buffers left/right pairs arriving from the I2S receiver side in a small pair FIFO. On each frame request from the transmitter it presents one pair with its validity flag, 192-frame block position and channel-status bits. It handles start-up priming, underrun concealment and the channel-status block counter.

## Interface
- `DATA_W`, 24: audio sample width; output words are zero-extended to 32 bits.
- `FIFO_DEPTH`, 4: pair FIFO depth; power of two, ≥2.
- `PRIME_LEVEL`, 2: FIFO occupancy required before leaving PRIME; 1..FIFO_DEPTH.
- `MUTE_ON_UNDERRUN`, 1: 1 outputs zeros on underrun; 0 repeats the last pair.
- `clk`  in  1  system clock (24.576 MHz); one clock, all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run request; 0 returns to IDLE and flushes the FIFO.
- `in_left`, `in_right`  in  DATA_W each  sample pair from the I2S side.
- `in_valid`  in  1  pair present.
- `in_ready`  out  1  FIFO not full. A push occurs when `in_valid && in_ready`.
- `sample_rate_code`  in  4  placed in channel-status bits 24..27.
- `tx_req`  in  1  single-cycle pulse from the transmitter at each frame boundary.
- `data_left`, `data_right`  out  32 each  current pair to the transmitter.
- `validity`  out  1  1 = current pair not valid (priming or underrun).
- `cs_bit`  out  1  channel-status bit for the current frame, used for both subframes.
- `block_start`  out  1  1 while the current frame index is 0 (B preamble).
- `frame_index`  out  8  0..191.
- `underrun_count`  out  16  saturating count of underrun frames.

## Operation
- FIFO stores {left,right}. Pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are derived from the MSB compare. `level` spans 0..FIFO_DEPTH.
- Push and pop in the same cycle are both performed; `level` is unchanged.
- `in_ready` = !full. It does not anticipate a same-cycle pop.
- States:
  - IDLE: FIFO is held flushed and outputs sit at reset values. Go to PRIME when `enable`=1.
  - PRIME: each `tx_req` outputs zeros with `validity`=1 and advances `frame_index`, with no pop. Go to RUN when `level`≥PRIME_LEVEL, evaluated at `tx_req`; that same `tx_req` pops and outputs a valid pair.
  - RUN: each `tx_req` with FIFO non-empty pops and outputs that pair with `validity`=0. A `tx_req` with FIFO empty is an underrun: output zeros or hold the last pair per MUTE_ON_UNDERRUN, set `validity`=1, increment `underrun_count` (saturate at 0xFFFF), go to PRIME.
  - Any state: `enable`=0 goes to IDLE next cycle, flushes the FIFO, resets `frame_index`, and clears the data outputs and `cs_bit`. `validity` goes to 1. `underrun_count` is kept.
- `frame_index` advances on every `tx_req` in PRIME/RUN and wraps 191→0. `block_start` = (`frame_index`==0).
- Channel-status block, 192 bits, bit n sent at frame n:
  - bit 0 = 0 (consumer);
  - bit 2 = 1 (copy permitted);
  - bits 24..27 = `sample_rate_code`, with bit 24 = code[0];
  - all other bits 0.
- `sample_rate_code` is latched into the block register only when the index wraps to 0, or on the first frame after IDLE. Changes take effect at block boundaries only.
- `cs_bit` = cs_reg[`frame_index`].
- `tx_req` arriving in IDLE is ignored.

## Timing
- Reset values:
  - `in_ready`=1, `data_left`=`data_right`=0, `validity`=1, `cs_bit`=0;
  - `block_start`=1, `frame_index`=0, `underrun_count`=0;
  - state IDLE, FIFO empty.
- Output latency is 1 cycle. `tx_req` sampled high at edge N updates all frame outputs after edge N; they are held until the next `tx_req`.
- The first frame after leaving IDLE uses `frame_index`=0, so the first `tx_req` produces index 0 and `block_start`=1. Later `tx_req` increment the index.
- The FIFO pop and the output register load happen on the same edge. A pair pushed at edge N is poppable by a `tx_req` at edge N+1 or later.
- `tx_req` spacing is ≥2 cycles and is guaranteed by the transmitter; back-to-back `tx_req` is not supported.
- Reset asserted mid-frame clears everything asynchronously. After release, the first rising edge is in IDLE.

## Test plan
- Reset, then `enable`=1 and push pairs (0x000001,0x000002), (0x000003,0x000004), then pulse `tx_req` every 128 cycles:
  - first frame: zeros with `validity`=1 if `level`<2, else the first pair with `validity`=0;
  - `frame_index` 0, 1, 2…
- Continuous stream with `sample_rate_code`=4'b1100 for 192 frames:
  - `cs_bit`=1 exactly at frames 2, 26, 27;
  - `block_start` high only at index 0;
  - index wraps 191→0.
- Stop pushing in RUN with MUTE_ON_UNDERRUN=1:
  - next `tx_req` gives zeros, `validity`=1, `underrun_count`=1, state PRIME;
  - resume after 2 pushes.
  - Repeat with MUTE_ON_UNDERRUN=0: the last pair is held.
- Fill the FIFO to 4:
  - `in_ready`=0;
  - a push and `tx_req` in the same cycle pop one and do not accept the push;
  - the next cycle `in_ready`=1.
- Change `sample_rate_code` to 4'b0000 at frame 10:
  - `cs_bit` at frames 26/27 stays 1 in the current block;
  - the next block shows 0.
- `enable`=0 mid-stream, then reset asserted mid-frame:
  - outputs go to reset values;
  - FIFO is empty;
  - `underrun_count` is kept across `enable`=0 and cleared only by reset.
